pc_predict: RTL and testbench
=============================

// Module: pc_predict
// PURPOSE
//   Registered fetch-PC generator for the pipelined core; successor to the
//   combinational PC/branch-select logic. Holds the fetch PC and predicts the
//   next PC with a direct-mapped BHT/BTB of 2-bit saturating counters.
//   Resolves branches from EX, flushes younger stages and redirects fetch on a
//   mispredict. Sits between the IF stage and the EX branch-compare logic.
// PARAMETERS
//   XLEN       32  address/immediate width
//   BHT_DEPTH  16  BHT/BTB entries; power of 2, >=2
//   RESET_PC   0   fetch PC loaded on reset
//   IMM_SHIFT  1   left shift applied to ex_imm to form the branch offset
// PORTS
//   clk            in   1     clock, rising edge
//   rst_n          in   1     asynchronous active-low reset
//   stall          in   1     hold fetch PC (hazard/ICache miss)
//   pc             out  XLEN  current fetch PC (register output)
//   pred_taken     out  1     prediction for pc (comb. from BHT read)
//   pred_target    out  XLEN  predicted target for pc (valid if pred_taken)
//   ex_valid       in   1     EX stage holds a valid instruction
//   ex_is_branch   in   1     that instruction is a conditional branch
//   ex_cond        in   1     branch condition result (1 = taken)
//   ex_pc          in   XLEN  PC of the EX instruction
//   ex_imm         in   XLEN  branch immediate (pre-shift)
//   ex_pred_taken  in   1     pred_taken carried down the pipe with it
//   ex_pred_target in   XLEN  pred_target carried down the pipe with it
//   flush          out  1     kill IF/ID this cycle (comb.)
// BEHAVIOUR
//   - idx = pc[$clog2(BHT_DEPTH)+1:2]; entry = {valid, ctr[1:0], target[XLEN-1:0]}.
//   - pred_taken = valid[idx] & ctr[idx][1]; pred_target = target[idx].
//   - act_taken = ex_cond; act_tgt = ex_pc + (ex_imm << IMM_SHIFT), mod 2^XLEN.
//   - resolve = ex_valid & ex_is_branch. Non-branch EX: no update, no flush.
//   - mispredict = resolve & ((act_taken != ex_pred_taken) |
//       (act_taken & ex_pred_taken & act_tgt != ex_pred_target)).
//   - flush = mispredict (same cycle, combinational).
//   - Next-PC priority: mispredict -> (act_taken ? act_tgt : ex_pc+4);
//     else stall -> pc; else pred_taken -> pred_target; else pc+4.
//     Redirect overrides stall. All PC adds wrap mod 2^XLEN (0xFFFFFFFC+4=0).
//   - Update on resolve, entry at ex_pc index: ctr saturating inc if taken
//     (max 2'b11), dec if not (min 2'b00); if taken: target<=act_tgt, valid<=1.
//     Update occurs regardless of stall.
//   - Same-cycle lookup and update of one index: lookup sees pre-update
//     state (read-before-write); new state visible next cycle.
//   - Aliasing is allowed; wrong targets are caught by the target compare.
//   - Latency: redirect PC appears on pc one cycle after mispredict.
//   - Reset (async, any time, incl. mid-redirect): pc<=RESET_PC, all valid<=0,
//     all ctr<=2'b01; hence pred_taken=0, pred_target=0, flush=0 (when EX
//     inputs idle).
// CONFIGURATION
//   PC_PREDICT_EN defined: BHT/BTB as above.
//   PC_PREDICT_EN undefined: no storage; static not-taken; pred_taken=0,
//     pred_target=0; flush on every taken resolved branch; next-PC priority
//     and wrap rules unchanged.
// TESTING
//   1 rst_n=0 -> pc=RESET_PC(0), pred_taken=0, flush=0; release, idle ->
//     pc 0x0,0x4,0x8 on successive edges.
//   2 pc=0x8, stall=1 for 2 cycles -> pc holds 0x8; stall=0 -> 0xC.
//   3 resolve ex_pc=0x10, ex_imm=0x8, ex_cond=1, ex_pred_taken=0 ->
//     flush=1, next pc=0x20; entry 4: ctr 01->10, target=0x20, valid=1.
//   4 then fetch pc=0x10 -> pred_taken=1, pred_target=0x20, next pc=0x20;
//     resolve taken with ex_pred_target=0x20 -> flush=0, ctr 10->11.
//   5 stall=1 with mispredict (ex_pc=0x10, ex_cond=0, ex_pred_taken=1) ->
//     flush=1, next pc=0x14 (redirect beats stall); ctr decrements.
//   6 pc=0xFFFFFFFC, no prediction -> next pc=0x0; without PC_PREDICT_EN
//     repeat 3/4 -> pred_taken always 0, flush=1 on each taken branch.

Source files
------------

// File: rtl/pc_predict.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pc_predict: registered fetch PC with direct-mapped BHT/BTB next-PC        |
// | prediction and EX-stage branch resolution / redirect.                     |
// | Optional feature macro: PC_PREDICT_EN (undefined = static not-taken).     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module pc_predict #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     BHT_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     IMM_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_cond,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] act_tgt, seq_pc, ex_seq_pc;
  logic            resolve, act_taken, mispredict;

  assign act_taken = ex_cond;
  assign act_tgt   = ex_pc + (ex_imm << IMM_SHIFT);
  assign seq_pc    = pc_q + XLEN'(4);
  assign ex_seq_pc = ex_pc + XLEN'(4);
  assign resolve   = ex_valid & ex_is_branch;

`ifdef PC_PREDICT_EN
  logic [BHT_DEPTH-1:0] valid_q;
  logic [1:0]           ctr_q [BHT_DEPTH];
  logic [XLEN-1:0]      tgt_q [BHT_DEPTH];
  logic [IDX_W-1:0]     rd_idx, wr_idx;

  assign rd_idx      = pc_q[IDX_W+1:2];
  assign wr_idx      = ex_pc[IDX_W+1:2];
  assign pred_taken  = valid_q[rd_idx] & ctr_q[rd_idx][1];
  assign pred_target = tgt_q[rd_idx];
  assign mispredict  = resolve & ((act_taken != ex_pred_taken) |
                       (act_taken & ex_pred_taken & (act_tgt != ex_pred_target)));

  // Table update is independent of stall; lookups see the pre-update entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        ctr_q[i] <= 2'b01;
        tgt_q[i] <= '0;
      end
    end else if (resolve) begin
      if (act_taken) begin
        if (ctr_q[wr_idx] != 2'b11) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
        tgt_q[wr_idx]   <= act_tgt;
        valid_q[wr_idx] <= 1'b1;
      end else if (ctr_q[wr_idx] != 2'b00) begin
        ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
      end
    end
  end
`else
  logic unused_pred;

  assign pred_taken  = 1'b0;
  assign pred_target = '0;
  assign mispredict  = resolve & act_taken;
  assign unused_pred = ^{ex_pred_taken, ex_pred_target};
`endif

  always_comb begin
    pc_d = seq_pc;
    if (mispredict)      pc_d = act_taken ? act_tgt : ex_seq_pc;
    else if (stall)      pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc    = pc_q;
  assign flush = mispredict;

endmodule
`default_nettype wire

// File: tb/tb_pc_predict.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pc_predict: vector-table bench for pc_predict (either PC_PREDICT_EN).   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_pc_predict;

  typedef struct {
    logic        st, v, br, c;
    logic [31:0] epc, imm;
    logic        ept;
    logic [31:0] eptgt;
    logic        fl, pt;
    logic [31:0] ptgt, npc;
  } vec_t;

  typedef struct {
    logic        fl, pt;
    logic [31:0] ptgt, npc;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_cond = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_imm = '0, ex_pred_target = '0;
  logic [31:0] pc, pred_target;
  logic        pred_taken, flush;

  int   n_pass = 0, n_total = 0;
  vec_t tbl [21];
  exp_t sbq [$];

  pc_predict dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_cond(ex_cond),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .flush(flush)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic st, v, br, c, input logic [31:0] epc, imm,
                              input logic ept, input logic [31:0] eptgt,
                              input logic fl, pt, input logic [31:0] ptgt, npc);
    vec_t r;
    r.st = st; r.v = v; r.br = br; r.c = c; r.epc = epc; r.imm = imm;
    r.ept = ept; r.eptgt = eptgt; r.fl = fl; r.pt = pt; r.ptgt = ptgt; r.npc = npc;
    return r;
  endfunction

  function automatic vec_t idle(input logic pt, input logic [31:0] ptgt, npc);
    return mk(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, pt, ptgt, npc);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t r);
    exp_t e;
    stall = r.st; ex_valid = r.v; ex_is_branch = r.br; ex_cond = r.c;
    ex_pc = r.epc; ex_imm = r.imm; ex_pred_taken = r.ept; ex_pred_target = r.eptgt;
    e.fl = r.fl; e.pt = r.pt; e.ptgt = r.ptgt; e.npc = r.npc;
    sbq.push_back(e);
  endtask

  task automatic check_comb(input string tag, output logic [31:0] npc);
    exp_t e;
    if (sbq.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard: empty queue, got 0 entries expected 1", tag);
      npc = '0;
    end else begin
      e = sbq.pop_front();
      chk({tag, ".flush"},       {31'b0, flush},      {31'b0, e.fl});
      chk({tag, ".pred_taken"},  {31'b0, pred_taken}, {31'b0, e.pt});
      chk({tag, ".pred_target"}, pred_target,         e.ptgt);
      npc = e.npc;
    end
  endtask

  initial begin
    logic [31:0] npc;
`ifdef PC_PREDICT_EN
    tbl[0]  = idle(0, 32'h0, 32'h4);
    tbl[1]  = idle(0, 32'h0, 32'h8);
    tbl[2]  = mk(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h8);
    tbl[3]  = mk(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h8);
    tbl[4]  = idle(0, 32'h0, 32'hC);
    tbl[5]  = mk(0, 1, 1, 1, 32'h10, 32'h8, 0, 32'h0,  1, 0, 32'h0, 32'h20);
    tbl[6]  = mk(0, 1, 1, 1, 32'h8,  32'h4, 0, 32'h0,  1, 0, 32'h0, 32'h10);
    tbl[7]  = idle(1, 32'h20, 32'h20);
    tbl[8]  = mk(0, 1, 1, 1, 32'h10, 32'h8, 1, 32'h20, 0, 0, 32'h0, 32'h24);
    tbl[9]  = mk(1, 1, 1, 0, 32'h10, 32'h8, 1, 32'h20, 1, 0, 32'h0, 32'h14);
    tbl[10] = mk(0, 1, 1, 0, 32'h10, 32'h8, 1, 32'h20, 1, 0, 32'h0, 32'h14);
    tbl[11] = mk(0, 1, 1, 1, 32'h8,  32'h4, 0, 32'h0,  1, 0, 32'h0, 32'h10);
    tbl[12] = idle(0, 32'h20, 32'h14);
    tbl[13] = mk(0, 1, 1, 1, 32'h0, 32'h7FFFFFFE, 0, 32'h0, 1, 0, 32'h0, 32'hFFFFFFFC);
    tbl[14] = idle(0, 32'h0, 32'h0);
    tbl[15] = idle(1, 32'hFFFFFFFC, 32'hFFFFFFFC);
    tbl[16] = mk(0, 0, 1, 1, 32'h0,  32'h4, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    tbl[17] = mk(0, 1, 0, 1, 32'h40, 32'h4, 0, 32'h0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC);
    tbl[18] = mk(0, 1, 1, 1, 32'h3C, 32'h2, 0, 32'h0, 1, 0, 32'h0, 32'h40);
    tbl[19] = idle(1, 32'hFFFFFFFC, 32'hFFFFFFFC);
    tbl[20] = idle(1, 32'h40, 32'h40);
`else
    tbl[0]  = idle(0, 32'h0, 32'h4);
    tbl[1]  = idle(0, 32'h0, 32'h8);
    tbl[2]  = mk(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h8);
    tbl[3]  = mk(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h8);
    tbl[4]  = idle(0, 32'h0, 32'hC);
    tbl[5]  = mk(0, 1, 1, 1, 32'h10, 32'h8, 0, 32'h0, 1, 0, 32'h0, 32'h20);
    tbl[6]  = mk(0, 1, 1, 1, 32'h8,  32'h4, 0, 32'h0, 1, 0, 32'h0, 32'h10);
    tbl[7]  = idle(0, 32'h0, 32'h14);
    tbl[8]  = mk(0, 1, 1, 1, 32'h10, 32'h8, 0, 32'h0, 1, 0, 32'h0, 32'h20);
    tbl[9]  = mk(1, 1, 1, 1, 32'h10, 32'h2, 0, 32'h0, 1, 0, 32'h0, 32'h14);
    tbl[10] = mk(0, 1, 1, 0, 32'h10, 32'h8, 0, 32'h0, 0, 0, 32'h0, 32'h18);
    tbl[11] = mk(0, 1, 1, 1, 32'h8,  32'h4, 0, 32'h0, 1, 0, 32'h0, 32'h10);
    tbl[12] = idle(0, 32'h0, 32'h14);
    tbl[13] = mk(0, 1, 1, 1, 32'h0, 32'h7FFFFFFE, 0, 32'h0, 1, 0, 32'h0, 32'hFFFFFFFC);
    tbl[14] = idle(0, 32'h0, 32'h0);
    tbl[15] = idle(0, 32'h0, 32'h4);
    tbl[16] = mk(0, 0, 1, 1, 32'h0,  32'h4, 0, 32'h0, 0, 0, 32'h0, 32'h8);
    tbl[17] = mk(0, 1, 0, 1, 32'h40, 32'h4, 0, 32'h0, 0, 0, 32'h0, 32'hC);
    tbl[18] = mk(0, 1, 1, 1, 32'h3C, 32'h2, 0, 32'h0, 1, 0, 32'h0, 32'h40);
    tbl[19] = idle(0, 32'h0, 32'h44);
    tbl[20] = idle(0, 32'h0, 32'h48);
`endif

    // Reset state with idle EX inputs
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc",          pc,                    32'h0);
    chk("reset.pred_taken",  {31'b0, pred_taken},   32'h0);
    chk("reset.pred_target", pred_target,           32'h0);
    chk("reset.flush",       {31'b0, flush},        32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      #2;
      check_comb($sformatf("vec%0d", i), npc);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.pc", i), pc, npc);
      @(negedge clk);
    end

    // Asynchronous reset asserted mid-cycle while a redirect is pending
    drive(mk(0, 1, 1, 1, 32'h8, 32'h4, 0, 32'h0, 1, 0, 32'h0, 32'h10));
    #2;
    check_comb("redir", npc);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst.pc", pc, 32'h0);
    drive(idle(0, 32'h0, 32'h0));
    #1;
    check_comb("async_rst", npc);
    @(posedge clk);
    #1;
    chk("async_rst.hold_pc", pc, npc);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle(0, 32'h0, 32'h4));
    #2;
    check_comb("post_rst", npc);
    @(posedge clk);
    #1;
    chk("post_rst.pc0", pc, npc);
    @(posedge clk);
    #1;
    chk("post_rst.pc1", pc, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
